// File: rtl/sp_ram_rr_arbiter_pkg.sv
// Shared types and helpers for the single-port RAM round-robin arbiter.
package sp_ram_arb_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned BE_WIDTH       = DEF_DATA_WIDTH / 8;
  localparam int unsigned MAX_PORTS      = 8;

  typedef enum logic {
    ARB,
    LOCKED
  } arb_state_e;

  // One-hot pick of the first requester at or after ptr, wrapping at n.
  function automatic logic [MAX_PORTS-1:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                                   input logic [2:0]           ptr,
                                                   input int unsigned          n);
    logic [MAX_PORTS-1:0] gnt;
    logic [2:0]           sel;
    gnt = '0;
    for (int unsigned k = 0; k < n; k++) begin
      sel = 3'((32'(ptr) + k) % n);
      if (gnt == '0 && req[sel]) gnt[sel] = 1'b1;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/sp_ram_rr_arbiter_if.sv
// Requester-side bundle of the RAM arbiter: per-port request buses plus the shared response.
interface sp_ram_rr_arbiter_if #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [NUM_PORTS-1:0]              req_i;
  logic [NUM_PORTS-1:0]              lock_i;
  logic [NUM_PORTS-1:0]              we_i;
  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i;
  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i;
  logic [NUM_PORTS-1:0]              gnt_o;
  logic [NUM_PORTS-1:0]              rvalid_o;
  logic [DATA_WIDTH-1:0]             rdata_o;

  modport master (
    output req_i, lock_i, we_i, addr_i, wdata_i, be_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, lock_i, we_i, addr_i, wdata_i, be_i,
    output gnt_o, rvalid_o, rdata_o
  );

endinterface

// File: rtl/sp_ram_rr_arbiter_core.sv
// Round-robin pick from the rotating pointer; the pointer follows the final grant.
module rr_arb_core
  import sp_ram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] gnt,
  output logic [NUM_PORTS-1:0] rr_gnt
);

  logic [2:0]           rr_ptr;
  logic [2:0]           ptr_d;
  logic [MAX_PORTS-1:0] req_ext;
  logic [MAX_PORTS-1:0] pick;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_PORTS-1:0] = req;
    pick                   = rr_pick(req_ext, rr_ptr, NUM_PORTS);
    rr_gnt                 = pick[NUM_PORTS-1:0];
  end

  // gnt may be a locked regrant rather than rr_gnt; the pointer still moves past it.
  always_comb begin
    ptr_d = rr_ptr;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (gnt[p]) ptr_d = (p == NUM_PORTS - 1) ? 3'd0 : 3'(p + 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr <= '0;
    else     rr_ptr <= ptr_d;
  end

endmodule

// File: rtl/sp_ram_rr_arbiter.sv
// Shares one single-port byte-enable RAM among NUM_PORTS requesters with
// round-robin arbitration, bounded per-port locking and a 1-cycle response path.
module sp_ram_rr_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_LOCK   = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  sp_ram_rr_arbiter_if.slave      bus,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int unsigned BW = DATA_WIDTH / 8;
  localparam int unsigned CW = (MAX_LOCK > 0) ? $clog2(MAX_LOCK + 1) : 1;

  arb_state_e           state_q, state_d;
  logic [2:0]           last_gnt_q, last_gnt_d;
  logic [CW-1:0]        lock_cnt_q, lock_cnt_d;
  logic [NUM_PORTS-1:0] rr_gnt;
  logic [NUM_PORTS-1:0] gnt;
  logic [NUM_PORTS-1:0] rvalid_q;
  logic                 hold;
  logic                 others;
  logic                 force_break;

  rr_arb_core #(
    .NUM_PORTS(NUM_PORTS)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req_i),
    .gnt    (gnt),
    .rr_gnt (rr_gnt)
  );

  always_comb begin
    hold   = 1'b0;
    others = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (3'(p) == last_gnt_q) hold   = bus.req_i[p];
      else                     others = others | bus.req_i[p];
    end
    hold        = hold && (state_q == LOCKED);
    force_break = hold && (lock_cnt_q == CW'(MAX_LOCK)) && others;

    gnt        = rr_gnt;
    state_d    = ARB;
    last_gnt_d = last_gnt_q;
    lock_cnt_d = '0;

    // Saturate the run length so a lone locked requester keeps its grant indefinitely.
    if (hold && !force_break) begin
      gnt = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (3'(p) == last_gnt_q) gnt[p] = 1'b1;
      end
      lock_cnt_d = (lock_cnt_q == CW'(MAX_LOCK)) ? lock_cnt_q : lock_cnt_q + CW'(1);
    end

    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (gnt[p]) begin
        last_gnt_d = 3'(p);
        state_d    = bus.lock_i[p] ? LOCKED : ARB;
      end
    end
    if (state_d != LOCKED) lock_cnt_d = '0;
  end

  always_comb begin
    mem_en_o    = |gnt;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (gnt[p]) begin
        mem_we_o    = bus.we_i[p];
        mem_addr_o  = bus.addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata_o = bus.wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
        mem_be_o    = bus.be_i[p*BW +: BW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB;
      last_gnt_q <= '0;
      lock_cnt_q <= '0;
      rvalid_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= gnt;
    end
  end

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = (|rvalid_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_sp_ram_rr_arbiter.sv
// Bench for sp_ram_rr_arbiter: directed table, reset/wrap sequences and a randomized run against a reference model.
module tb_sp_ram_rr_arbiter;

  localparam int NP = 2;
  localparam int ML = 3;
  localparam logic [31:0] D = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sp_ram_rr_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  sp_ram_rr_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(8), .DATA_WIDTH(32), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
  );

  sp_ram_rr_arbiter_if #(.NUM_PORTS(3), .ADDR_WIDTH(8), .DATA_WIDTH(32)) bus3 ();
  logic        m3_en, m3_we;
  logic [7:0]  m3_addr;
  logic [31:0] m3_wdata;
  logic [3:0]  m3_be;

  sp_ram_rr_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(8), .DATA_WIDTH(32), .MAX_LOCK(15)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3),
    .mem_en_o(m3_en), .mem_we_o(m3_we), .mem_addr_o(m3_addr),
    .mem_wdata_o(m3_wdata), .mem_be_o(m3_be), .mem_rdata_i(32'h0)
  );

  // Behavioural sp_ram_m32: registered read, byte-enable write.
  logic [31:0] ram [0:255];
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  always @(posedge clk) begin
    if (load_en) ram[load_addr] <= load_data;
    else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else mem_rdata <= ram[mem_addr];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  req, lock, we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [1:0]  gnt;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] we,
                              input logic [7:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                              input logic [1:0] gnt, input logic [31:0] rd);
    vec_t r;
    r.req = req; r.lock = lock; r.we = we; r.addr = addr;
    r.wdata = wdata; r.be = be; r.gnt = gnt; r.rd = rd;
    return r;
  endfunction

  task automatic drive(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] we,
                       input logic [15:0] addr, input logic [63:0] wdata, input logic [7:0] be);
    bus.req_i = req; bus.lock_i = lock; bus.we_i = we;
    bus.addr_i = addr; bus.wdata_i = wdata; bus.be_i = be;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // Reference model: a pointer, the current lock owner (-1 if none) and its regrant run.
  typedef struct { int ptr; int owner; int run; } mstate_t;

  task automatic model_step(input mstate_t s, input logic [7:0] req, input logic [7:0] lock,
                            input int n, input int maxl, output int g, output mstate_t ns);
    bit stay, others;
    g = -1; stay = 0; others = 0;
    if (s.owner >= 0 && req[s.owner]) begin
      for (int k = 0; k < n; k++) if (k != s.owner && req[k]) others = 1;
      if (!(s.run == maxl && others)) begin g = s.owner; stay = 1; end
    end
    if (g < 0)
      for (int k = 0; k < n; k++)
        if (g < 0 && req[(s.ptr + k) % n]) g = (s.ptr + k) % n;
    ns = s;
    if (g >= 0) begin
      ns.ptr   = (g + 1) % n;
      ns.run   = stay ? ((s.run < maxl) ? s.run + 1 : maxl) : 0;
      ns.owner = lock[g] ? g : -1;
    end else begin
      ns.owner = -1;
      ns.run   = 0;
    end
  endtask

  logic [31:0] ref_mem [0:255];

  initial begin
    logic [1:0]  prev_gnt;
    logic [31:0] prev_rd;
    logic        prev_wr;
    mstate_t     ms, ns;
    int          g, prev_g;
    logic        prev_g_wr;
    logic [31:0] prev_exp_rd;
    logic [1:0]  r_req, r_lock, r_we;
    logic [7:0]  ra [2];
    logic [31:0] rw [2];
    logic [3:0]  rb [2];
    logic [31:0] wv;

    drive('0, '0, '0, '0, '0, '0);
    bus3.req_i = '0; bus3.lock_i = '0; bus3.we_i = '0;
    bus3.addr_i = {8'h32, 8'h31, 8'h30}; bus3.wdata_i = '0; bus3.be_i = '0;

    load(8'h05, D);
    load(8'h10, 32'hAAAAAAAA);
    for (int a = 8'h80; a < 8'h90; a++) begin
      load(8'(a), 32'hC0DE0000 | 32'(a));
      ref_mem[a] = 32'hC0DE0000 | 32'(a);
    end

    @(negedge clk);
    chk("reset_rvalid", bus.rvalid_o, 2'b00);
    chk("reset_gnt", bus.gnt_o, 2'b00);
    chk("reset_mem_en", mem_en, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // req, lock, we, addr, wdata, be, expected gnt, expected read data
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 8'h05, 0, 4'h0, 2'b00, 0));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 8'h05, 0, 4'h0, 2'b01, D));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 8'h05, 0, 4'h0, 2'b10, D));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 8'h05, 0, 4'h0, 2'b01, D));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 8'h05, 0, 4'h0, 2'b10, D));
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, 8'h05, 0, 4'h0, 2'b01, D));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 8'h05, 0, 4'h0, 2'b00, 0));
    tbl.push_back(mk(2'b10, 2'b00, 2'b10, 8'h10, 32'h11223344, 4'b0101, 2'b10, 0));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 8'h10, 0, 4'h0, 2'b10, 32'hAA22AA44));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 8'h05, 0, 4'h0, 2'b00, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(2'b11, 2'b01, 2'b00, 8'h05, 0, 4'h0, 2'b01, D));
    tbl.push_back(mk(2'b11, 2'b01, 2'b00, 8'h05, 0, 4'h0, 2'b10, D));
    tbl.push_back(mk(2'b11, 2'b01, 2'b00, 8'h05, 0, 4'h0, 2'b01, D));
    tbl.push_back(mk(2'b11, 2'b01, 2'b00, 8'h05, 0, 4'h0, 2'b01, D));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 8'h05, 0, 4'h0, 2'b10, D));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 8'h05, 0, 4'h0, 2'b01, D));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 8'h05, 0, 4'h0, 2'b10, D));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(2'b01, 2'b01, 2'b00, 8'h05, 0, 4'h0, 2'b01, D));
    tbl.push_back(mk(2'b11, 2'b01, 2'b00, 8'h05, 0, 4'h0, 2'b10, D));
    tbl.push_back(mk(2'b11, 2'b01, 2'b00, 8'h05, 0, 4'h0, 2'b01, D));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 8'h05, 0, 4'h0, 2'b01, D));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 8'h05, 0, 4'h0, 2'b10, D));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 8'h05, 0, 4'h0, 2'b00, 0));

    prev_gnt = '0; prev_rd = '0; prev_wr = 1'b0;
    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].lock, tbl[i].we, {2{tbl[i].addr}}, {2{tbl[i].wdata}}, {2{tbl[i].be}});
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", i), bus.gnt_o, tbl[i].gnt);
      chk($sformatf("tbl%0d_mem_en", i), mem_en, |tbl[i].gnt);
      chk($sformatf("tbl%0d_rvalid", i), bus.rvalid_o, prev_gnt);
      if (prev_gnt == 2'b00)
        chk($sformatf("tbl%0d_rdata_gate", i), bus.rdata_o, 32'h0);
      else if (!prev_wr)
        chk($sformatf("tbl%0d_rdata", i), bus.rdata_o, prev_rd);
      prev_gnt = tbl[i].gnt;
      prev_rd  = tbl[i].rd;
      prev_wr  = |(tbl[i].we & tbl[i].gnt);
      @(posedge clk); #1;
    end

    // Reset while a read response is in flight.
    drive(2'b01, 2'b00, 2'b00, {2{8'h05}}, '0, '0);
    @(negedge clk);
    chk("midrst_gnt", bus.gnt_o, 2'b01);
    @(posedge clk); #1;
    chk("midrst_rvalid_pre", bus.rvalid_o, 2'b01);
    rst = 1'b1; #1;
    chk("midrst_rvalid", bus.rvalid_o, 2'b00);
    chk("midrst_rdata", bus.rdata_o, 32'h0);
    drive('0, '0, '0, '0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(2'b11, 2'b00, 2'b00, {2{8'h05}}, '0, '0);
    @(negedge clk);
    chk("midrst_ptr", bus.gnt_o, 2'b01);
    @(posedge clk); #1;
    drive('0, '0, '0, '0, '0, '0);
    @(posedge clk); #1;

    // Three-port pointer wrap.
    bus3.req_i = 3'b010; @(negedge clk);
    chk("wrap_g1", bus3.gnt_o, 3'b010);
    @(posedge clk); #1;
    bus3.req_i = 3'b011; @(negedge clk);
    chk("wrap_g2", bus3.gnt_o, 3'b001);
    chk("wrap_addr", m3_addr, 8'h30);
    chk("wrap_rvalid1", bus3.rvalid_o, 3'b010);
    @(posedge clk); #1;
    bus3.req_i = 3'b011; @(negedge clk);
    chk("wrap_g3", bus3.gnt_o, 3'b010);
    chk("wrap_rvalid2", bus3.rvalid_o, 3'b001);
    @(posedge clk); #1;
    bus3.req_i = 3'b100; @(negedge clk);
    chk("wrap_g4", bus3.gnt_o, 3'b100);
    chk("wrap_addr2", m3_addr, 8'h32);
    @(posedge clk); #1;
    bus3.req_i = 3'b101; @(negedge clk);
    chk("wrap_g5", bus3.gnt_o, 3'b001);
    @(posedge clk); #1;
    bus3.req_i = 3'b000; @(negedge clk);
    chk("wrap_idle_en", m3_en, 1'b0);
    @(posedge clk); #1;

    // Randomized run against the reference model.
    rst = 1'b1; #1; rst = 1'b0;
    ms.ptr = 0; ms.owner = -1; ms.run = 0;
    prev_g = -1; prev_g_wr = 1'b0; prev_exp_rd = '0;
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < NP; p++) begin
        r_req[p]  = ($urandom_range(0, 3) != 0);
        r_lock[p] = ($urandom_range(0, 2) != 0);
        r_we[p]   = ($urandom_range(0, 2) == 0);
        ra[p]     = 8'h80 + 8'($urandom_range(0, 15));
        rw[p]     = $urandom;
        rb[p]     = 4'($urandom_range(0, 15));
      end
      drive(r_req, r_lock, r_we, {ra[1], ra[0]}, {rw[1], rw[0]}, {rb[1], rb[0]});
      model_step(ms, 8'(r_req), 8'(r_lock), NP, ML, g, ns);
      @(negedge clk);
      chk("rnd_gnt", bus.gnt_o, (g >= 0) ? 2'(1 << g) : 2'b00);
      chk("rnd_mem_en", mem_en, g >= 0);
      chk("rnd_rvalid", bus.rvalid_o, (prev_g >= 0) ? 2'(1 << prev_g) : 2'b00);
      if (prev_g < 0) chk("rnd_rdata_gate", bus.rdata_o, 32'h0);
      else if (!prev_g_wr) chk("rnd_rdata", bus.rdata_o, prev_exp_rd);
      if (g >= 0) begin
        chk("rnd_mem_we", mem_we, r_we[g]);
        chk("rnd_mem_addr", mem_addr, ra[g]);
        chk("rnd_mem_wdata", mem_wdata, rw[g]);
        chk("rnd_mem_be", mem_be, rb[g]);
        if (r_we[g]) begin
          wv = ref_mem[ra[g]];
          for (int b = 0; b < 4; b++) if (rb[g][b]) wv[8*b +: 8] = rw[g][8*b +: 8];
          ref_mem[ra[g]] = wv;
        end else prev_exp_rd = ref_mem[ra[g]];
        prev_g_wr = r_we[g];
      end else begin
        chk("rnd_idle_addr", mem_addr, 8'h00);
        chk("rnd_idle_wdata", mem_wdata, 32'h0);
      end
      prev_g = g;
      ms = ns;
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1);
  end

endmodule
